// File: rtl/m_seq_pkg.sv
// Shared constants and types for the 10-bit m-sequence generator/checker pair.
// Polynomial x^10+x^3+1; the checker predicts s[n] = s[n-7] ^ s[n-10].
package m_seq_pkg;

  localparam int LFSR_W = 10;
  localparam logic [LFSR_W-1:0] POLY_MASK = 10'h009;
  localparam int TAP_A = 6;
  localparam int TAP_B = 9;
  localparam int FRAME_LEN_DEF = 1023;
  localparam int RESYNC_ERR_DEF = 4;
  localparam int CNT_W = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/m_seq_predict.sv
// Received-bit history register and next-bit prediction for the m-sequence checker.
// hist_reg[0] holds the newest bit.
module m_seq_predict
  import m_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift,
  input  logic din,
  output logic pred,
  output logic next_zero
);

  logic [LFSR_W-1:0] hist_reg;
  logic [LFSR_W-1:0] hist_next;

  assign hist_next[0] = din;

  genvar gi;
  generate
    for (gi = 1; gi < LFSR_W; gi++) begin : g_shift
      assign hist_next[gi] = hist_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist_reg <= '0;
    end else if (shift) begin
      hist_reg <= hist_next;
    end
  end

  assign pred = hist_reg[TAP_A] ^ hist_reg[TAP_B];
  // An all-zero history is the LFSR lock-up state and cannot be tracked.
  assign next_zero = (hist_next == '0);

endmodule

// File: rtl/m_seq_checker.sv
// Self-synchronising m-sequence checker: fills from the line, then counts
// mismatches against the predicted bit over one frame.
module m_seq_checker #(
  parameter int LFSR_W     = 10,
  parameter int FRAME_LEN  = 1023,
  parameter int RESYNC_ERR = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        data,
  input  logic        valid,
  output logic        locked,
  output logic [10:0] err_count,
  output logic [10:0] bit_count,
  output logic        done,
  output logic        resync
);
  import m_seq_pkg::*;

  localparam int RUN_W = $clog2(RESYNC_ERR + 1);
  localparam logic [3:0] FILL_LAST = 4'(LFSR_W - 1);
  localparam logic [CNT_W-1:0] FRAME_END = CNT_W'(FRAME_LEN);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(RESYNC_ERR);

  state_t state_reg, state_next;
  logic [3:0] fill_cnt_reg, fill_cnt_next;
  logic [RUN_W-1:0] run_reg, run_next;
  logic [CNT_W-1:0] err_reg, err_next;
  logic [CNT_W-1:0] bit_reg, bit_next;
  logic locked_reg, locked_next;
  logic done_reg, done_next;
  logic resync_reg, resync_next;
  logic frame_end, lose_lock;
  logic accept, hist_clr, pred, next_zero, mismatch;

  assign accept = valid && ((state_reg == FILL) || (state_reg == CHECK));
  assign hist_clr = (state_reg == IDLE) || ((state_reg == DONE) && start);
  assign mismatch = data ^ pred;

  m_seq_predict u_predict (
    .clk       (clk),
    .rst       (rst),
    .clr       (hist_clr),
    .shift     (accept),
    .din       (data),
    .pred      (pred),
    .next_zero (next_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      fill_cnt_reg <= '0;
      run_reg      <= '0;
      err_reg      <= '0;
      bit_reg      <= '0;
      locked_reg   <= 1'b0;
      done_reg     <= 1'b0;
      resync_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      fill_cnt_reg <= fill_cnt_next;
      run_reg      <= run_next;
      err_reg      <= err_next;
      bit_reg      <= bit_next;
      locked_reg   <= locked_next;
      done_reg     <= done_next;
      resync_reg   <= resync_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fill_cnt_next = fill_cnt_reg;
    run_next      = run_reg;
    err_next      = err_reg;
    bit_next      = bit_reg;
    frame_end     = 1'b0;
    lose_lock     = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next    = FILL;
          fill_cnt_next = '0;
          run_next      = '0;
          err_next      = '0;
          bit_next      = '0;
        end
      end
      FILL: begin
        if (valid) begin
          if (fill_cnt_reg == FILL_LAST) begin
            fill_cnt_next = '0;
            if (!next_zero) begin
              state_next = CHECK;
              run_next   = '0;
            end
          end else begin
            fill_cnt_next = fill_cnt_reg + 4'd1;
          end
        end
      end
      CHECK: begin
        if (valid) begin
          bit_next = bit_reg + 1'b1;
          if (mismatch && (err_reg != '1)) begin
            err_next = err_reg + 1'b1;
          end
          run_next = mismatch ? run_reg + 1'b1 : '0;
          // Frame completion takes priority over loss of lock on the last bit.
          if (bit_next == FRAME_END) begin
            frame_end  = 1'b1;
            state_next = DONE;
          end else if (run_next == RUN_LIMIT) begin
            lose_lock     = 1'b1;
            state_next    = FILL;
            fill_cnt_next = '0;
            run_next      = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    locked_next = (state_next == CHECK);
    done_next   = frame_end;
    resync_next = lose_lock;
  end

  assign locked    = locked_reg;
  assign err_count = err_reg;
  assign bit_count = bit_reg;
  assign done      = done_reg;
  assign resync    = resync_reg;

endmodule

// File: tb/tb_m_seq_checker.sv
// Bench for m_seq_checker: fixed vector table, then generator-driven and random
// frames compared cycle by cycle against a queue-based reference model.
module tb_m_seq_checker;

  localparam int FRAME = 1023;

  logic clk = 1'b0;
  logic rst, start, data, valid;
  logic locked, done, resync;
  logic [10:0] err_count, bit_count;

  always #5 clk = ~clk;

  m_seq_checker dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data      (data),
    .valid     (valid),
    .locked    (locked),
    .err_count (err_count),
    .bit_count (bit_count),
    .done      (done),
    .resync    (resync)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 fill, 2 check, 3 done; q holds bits since last fill start.
  int m_mode = 0;
  bit q[$];
  int m_err = 0, m_cnt = 0, m_run = 0;
  bit m_done = 0, m_resync = 0;

  task automatic model_step(input bit r, input bit s, input bit d, input bit v);
    int ones;
    bit p;
    m_done = 0;
    m_resync = 0;
    if (r) begin
      m_mode = 0; q.delete(); m_err = 0; m_cnt = 0; m_run = 0;
    end else begin
      case (m_mode)
        0, 3: if (s) begin
          m_mode = 1; q.delete(); m_err = 0; m_cnt = 0; m_run = 0;
        end
        1: if (v) begin
          q.push_back(d);
          if (q.size() == 10) begin
            ones = 0;
            foreach (q[i]) ones += int'(q[i]);
            if (ones == 0) q.delete();
            else begin m_mode = 2; m_run = 0; end
          end
        end
        2: if (v) begin
          p = q[q.size()-7] ^ q[q.size()-10];
          q.push_back(d);
          m_cnt++;
          if (d != p) begin
            if (m_err < 2047) m_err++;
            m_run++;
          end else m_run = 0;
          if (m_cnt == FRAME) begin
            m_mode = 3; m_done = 1;
          end else if (m_run == 4) begin
            m_mode = 1; m_resync = 1; q.delete(); m_run = 0;
          end
        end
        default: ;
      endcase
    end
  endtask

  int seen_done = 0, seen_resync = 0, accepted = 0;

  task automatic step(input bit r, input bit s, input bit d, input bit v);
    logic [24:0] exp;
    rst = r; start = s; data = d; valid = v;
    @(posedge clk);
    model_step(r, s, d, v);
    #1;
    exp = {(m_mode == 2), 11'(m_err), 11'(m_cnt), m_done, m_resync};
    check("cycle", {7'd0, locked, err_count, bit_count, done, resync}, {7'd0, exp});
    if (done) seen_done++;
    if (resync) seen_resync++;
  endtask

  logic [9:0] gen_r;

  // Drive one generator frame; bits with accepted index in [inv_lo,inv_hi] are inverted.
  task automatic run_frame(input int pct, input int inv_lo, input int inv_hi,
                           input int abort_k, input int budget);
    int k;
    bit v, d;
    gen_r = 10'h001;
    k = 0;
    seen_done = 0;
    seen_resync = 0;
    step(0, 1, 0, 0);
    for (int c = 0; c < budget && seen_done == 0 && k != abort_k; c++) begin
      v = ($urandom_range(99) < pct);
      d = 0;
      if (v) begin
        d = gen_r[9] ^ (k >= inv_lo && k <= inv_hi);
        gen_r = {gen_r[8:0], 1'b0} ^ (gen_r[9] ? 10'h009 : 10'h000);
        k++;
      end
      step(0, 0, d, v);
    end
    accepted = k;
  endtask

  typedef struct {
    bit r, s, d, v;
    bit lk;
    int er, bc;
    bit dn, rs;
  } vec_t;

  vec_t tbl[28];

  task automatic set_vec(input int i, input bit r, input bit s, input bit d, input bit v,
                         input bit lk, input int er, input int bc);
    tbl[i].r = r; tbl[i].s = s; tbl[i].d = d; tbl[i].v = v;
    tbl[i].lk = lk; tbl[i].er = er; tbl[i].bc = bc; tbl[i].dn = 0; tbl[i].rs = 0;
  endtask

  initial begin
    rst = 1; start = 0; data = 0; valid = 0;

    set_vec(0, 1, 0, 0, 0, 0, 0, 0);
    set_vec(1, 0, 0, 1, 1, 0, 0, 0);
    set_vec(2, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 3; i <= 12; i++) set_vec(i, 0, 0, 0, 1, 0, 0, 0);
    set_vec(13, 0, 1, 0, 1, 0, 0, 0);
    for (int i = 14; i <= 21; i++) set_vec(i, 0, 0, 0, 1, 0, 0, 0);
    set_vec(22, 0, 0, 1, 1, 1, 0, 0);
    set_vec(23, 0, 0, 0, 0, 1, 0, 0);
    set_vec(24, 0, 0, 0, 1, 1, 0, 1);
    set_vec(25, 0, 0, 1, 1, 1, 1, 2);
    set_vec(26, 0, 0, 0, 1, 1, 1, 3);
    set_vec(27, 1, 0, 0, 1, 0, 0, 0);

    @(posedge clk); #1;
    for (int i = 0; i < 28; i++) begin
      rst = tbl[i].r; start = tbl[i].s; data = tbl[i].d; valid = tbl[i].v;
      @(posedge clk); #1;
      check($sformatf("vec%0d_locked", i), {31'd0, locked}, {31'd0, tbl[i].lk});
      check($sformatf("vec%0d_err", i), {21'd0, err_count}, tbl[i].er);
      check($sformatf("vec%0d_bits", i), {21'd0, bit_count}, tbl[i].bc);
      check($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, tbl[i].dn});
      check($sformatf("vec%0d_resync", i), {31'd0, resync}, {31'd0, tbl[i].rs});
    end

    // Clean frame, continuous valid.
    step(1, 0, 0, 0);
    run_frame(100, -1, -1, -1, 1200);
    check("clean_done", seen_done, 1);
    check("clean_accepted", accepted, FRAME + 10);
    check("clean_err", {21'd0, err_count}, 0);
    check("clean_bits", {21'd0, bit_count}, FRAME);
    check("clean_resync", seen_resync, 0);
    step(0, 0, 1, 1);
    check("done_hold_bits", {21'd0, bit_count}, FRAME);

    // Check bit 100 inverted: error multiplication by three.
    step(1, 0, 0, 0);
    run_frame(100, 109, 109, -1, 1200);
    check("flip_done", seen_done, 1);
    check("flip_err", {21'd0, err_count}, 3);
    check("flip_resync", seen_resync, 0);

    // Constant zero never locks.
    step(1, 0, 0, 0);
    seen_done = 0;
    step(0, 1, 0, 0);
    for (int c = 0; c < 50; c++) step(0, 0, 0, 1);
    check("zero_locked", {31'd0, locked}, 0);
    check("zero_done", seen_done, 0);
    check("zero_bits", {21'd0, bit_count}, 0);

    // Four consecutive bad bits force a refill.
    step(1, 0, 0, 0);
    run_frame(100, 210, 213, -1, 1300);
    check("burst_resync", seen_resync, 1);
    check("burst_done", seen_done, 1);
    check("burst_err_ge4", {31'd0, (err_count >= 11'd4)}, 1);

    // Clean stream with random valid gaps.
    step(1, 0, 0, 0);
    run_frame(50, -1, -1, -1, 5000);
    check("gaps_done", seen_done, 1);
    check("gaps_accepted", accepted, FRAME + 10);
    check("gaps_err", {21'd0, err_count}, 0);

    // Reset in the middle of a frame, then a fresh frame.
    step(1, 0, 0, 0);
    run_frame(100, -1, -1, 510, 1200);
    step(1, 0, 0, 0);
    check("abort_out", {7'd0, locked, err_count, bit_count, done, resync}, 0);
    run_frame(100, -1, -1, -1, 1200);
    check("after_abort_done", seen_done, 1);
    check("after_abort_err", {21'd0, err_count}, 0);

    // Random data, valid and occasional start: model comparison only.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int c = 0; c < 2500; c++)
      step(0, ($urandom_range(199) == 0), 1'($urandom_range(1)), ($urandom_range(99) < 70));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/m_seq_checker.md
Name: m_seq_checker

Overview:
- Receive-side partner of the 10-bit m-sequence generator: takes the serial PN bit stream and self-synchronises to it.
- After synchronising, checks each bit against the value the polynomial predicts, and counts bit mismatches over one frame.
- Used for loopback BER tests: generator -> link/FPGA I/O -> checker. Reports lock, error count and a done pulse.

Parameters:
- LFSR_W, 10, sequence register width. The polynomial x^10+x^3+1 is fixed (generator feedback mask 10'h009).
- FRAME_LEN, 1023, number of checked bits per frame, counted after the fill phase.
- RESYNC_ERR, 4, number of consecutive mismatches that forces loss of lock and a re-fill.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; begins a measurement from IDLE or DONE
- data  in  1  received PN bit
- valid  in  1  data qualifier; only cycles with valid=1 advance the block
- locked  out  1  high while in CHECK
- err_count  out  11  mismatches in the current/last frame; saturates at 2047
- bit_count  out  11  checked bits in the current frame
- done  out  1  one-cycle pulse when the frame completes
- resync  out  1  one-cycle pulse when lock is lost

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state=IDLE; all outputs 0; history hist[9:0]=0.
  - Applies from any state and aborts a running frame; no done pulse is emitted.
- History register: on each accepted bit (valid=1 in FILL or CHECK), hist <= {hist[8:0], data}. hist[0] is the newest bit.
- Prediction, combinational: pred = hist[6] ^ hist[9], i.e. s[n] = s[n-7] ^ s[n-10]. This is the recurrence for characteristic polynomial x^10+x^3+1 and matches the generator's Galois output stream.
- States:
  - IDLE: wait for start -> FILL. Clears err_count, bit_count, fill counter and hist.
  - FILL: accepts 10 valid bits into hist (fill counter 0..9).
    - After the 10th bit, the next state depends on the new hist value: all-zero -> clear the fill counter and stay in FILL (all-zero is not a valid m-seq state); otherwise -> CHECK.
  - CHECK: on each valid bit, mismatch = data ^ pred.
    - bit_count += 1; err_count += mismatch, saturating at 2047.
    - The consecutive-error counter increments on a mismatch and clears on a match.
    - If it reaches RESYNC_ERR: resync pulse, go to FILL, clear the fill counter and consecutive counter. err_count and bit_count are kept.
    - When bit_count reaches FRAME_LEN: done pulse on the cycle after the last bit's edge; go to DONE.
  - DONE: outputs hold. start -> FILL with counters cleared.
- locked = (state==CHECK), registered.
- start is ignored in FILL and CHECK.
- Simultaneous events on the last frame bit: if the resync condition and bit_count==FRAME_LEN occur together, frame completion wins (done pulse, DONE state, no resync).
- valid=0 cycles: no state, counter or history change. Gaps of any length are tolerated.
- Self-synchronising error multiplication: one flipped line bit gives 3 mismatches (the bit itself, then 7 and 10 bits later), unless the flip falls within the last 10 bits of the frame.
- Latency: every output is registered. err_count/bit_count update 1 cycle after the valid edge that carries the bit.

Decomposition:
- Package m_seq_pkg:
  - LFSR_W = 10
  - POLY_MASK = 10'h009
  - tap indices TAP_A = 6, TAP_B = 9
  - FRAME_LEN_DEF = 1023
  - state enum IDLE/FILL/CHECK/DONE
  - The generator is to be switched to the same constants.
- Sub-module m_seq_predict: history shift register plus pred output, with shift-enable and clear inputs. Everything else (FSM, counters) stays in m_seq_checker.

Test Plan:
- Generator seeded 10'h001 drives data with valid=1 and start pulsed -> locked rises after 10 bits; done pulses after 1033 valid bits; err_count=0, bit_count=1023.
- Same stream with check bit 100 inverted -> err_count=3, done still pulses, resync never pulses.
- data=0 constant, valid=1 for 50 cycles after start -> remains in FILL, locked=0, no done.
- Lock obtained, then 4 consecutive inverted bits -> resync pulse; locked falls then rises again after 10 more valid bits; err_count ends ≥4.
- Random valid gaps (valid=1 ~50% of cycles) on a clean stream -> err_count=0, done after 1033 accepted bits.
- rst asserted at check bit 500 -> all outputs 0 next cycle, state IDLE; a new start gives a clean frame with err_count=0.
